ex_alu_issue: RTL and testbench

- Execute-stage front end of the RISC-V core. Accepts decoded operations from ID over a valid/ready handshake.
- Generates ALUCtl from ALUOp/funct3/funct7[5] and drives the combinational alu module.
- Resolves branches from Result/Zero, then buffers the outcome in a 2-entry skid register toward MEM.

---
 rtl/ex_alu_issue.sv | 176 +++++++++++++++++
 tb/tb_ex_alu_issue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_issue.sv
// Execute-stage issue front end: decodes ALU control for the external alu, resolves
// branches from its Result/Zero, and buffers each outcome in a 2-entry head/skid buffer.
module ex_alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Flush,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [1:0]            InALUOp,
    input  logic [2:0]            InFunct3,
    input  logic                  InFunct7b5,
    input  logic [DATA_WIDTH-1:0] InA,
    input  logic [DATA_WIDTH-1:0] InB,
    input  logic [RD_WIDTH-1:0]   InRd,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [3:0]            ALUCtl,
    input  logic [DATA_WIDTH-1:0] Result,
    input  logic                  Zero,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutResult,
    output logic [RD_WIDTH-1:0]   OutRd,
    output logic                  OutTaken,
    output logic                  OutIllegal
);

    localparam logic [3:0] ALU_ADD     = 4'h0;
    localparam logic [3:0] ALU_SUB     = 4'h1;
    localparam logic [3:0] ALU_SLL     = 4'h2;
    localparam logic [3:0] ALU_SLT     = 4'h3;
    localparam logic [3:0] ALU_SLTU    = 4'h4;
    localparam logic [3:0] ALU_XOR     = 4'h5;
    localparam logic [3:0] ALU_SRL     = 4'h6;
    localparam logic [3:0] ALU_SRA     = 4'h7;
    localparam logic [3:0] ALU_OR      = 4'h8;
    localparam logic [3:0] ALU_AND     = 4'h9;
    localparam logic [3:0] ALU_ILLEGAL = 4'hF;

    logic                  is_branch;
    logic [3:0]            alu_ctl;
    logic                  new_illegal;
    logic                  new_taken;
    logic [RD_WIDTH-1:0]   new_rd;

    logic [1:0]            count;
    logic [1:0]            count_next;
    logic                  in_ready_q;
    logic                  accept;
    logic                  pop;
    logic                  load_head_new;

    logic [DATA_WIDTH-1:0] head_result, skid_result;
    logic [RD_WIDTH-1:0]   head_rd, skid_rd;
    logic                  head_taken, skid_taken;
    logic                  head_illegal, skid_illegal;

    assign A         = InA;
    assign B         = InB;
    assign ALUCtl    = alu_ctl;
    assign is_branch = (InALUOp == 2'b01);

    always_comb begin
        alu_ctl     = ALU_ADD;
        new_illegal = 1'b0;
        case (InALUOp)
            2'b00: alu_ctl = ALU_ADD;
            2'b01: begin
                case (InFunct3)
                    3'b000, 3'b001: alu_ctl = ALU_SUB;
                    3'b100, 3'b101: alu_ctl = ALU_SLT;
                    3'b110, 3'b111: alu_ctl = ALU_SLTU;
                    default: begin
                        alu_ctl     = ALU_ILLEGAL;
                        new_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                // R-type and I-type share the table; only R-type has SUB (no SUBI).
                case (InFunct3)
                    3'b000:  alu_ctl = (InALUOp == 2'b10 && InFunct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctl = ALU_SLL;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b011:  alu_ctl = ALU_SLTU;
                    3'b100:  alu_ctl = ALU_XOR;
                    3'b101:  alu_ctl = InFunct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctl = ALU_OR;
                    default: alu_ctl = ALU_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        new_taken = 1'b0;
        if (is_branch) begin
            case (InFunct3)
                3'b000, 3'b101, 3'b111: new_taken = Zero;
                3'b001, 3'b100, 3'b110: new_taken = !Zero;
                default:                new_taken = 1'b0;
            endcase
        end
    end

    assign new_rd = (is_branch || new_illegal) ? '0 : InRd;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // InReady is a register (count_next < 2), so it never depends on OutReady in the same cycle.
    assign InReady  = in_ready_q;
    assign accept   = InValid && in_ready_q;
    assign OutValid = (count != 2'd0);
    assign pop      = OutValid && OutReady;

    assign load_head_new = (count == 2'd0) || (count == 2'd1 && pop);

    always_comb begin
        count_next = count;
        if (Flush) begin
            count_next = 2'd0;
        end else begin
            case ({accept, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= 2'd0;
            in_ready_q   <= 1'b1;
            head_result  <= '0;
            head_rd      <= '0;
            head_taken   <= 1'b0;
            head_illegal <= 1'b0;
            skid_result  <= '0;
            skid_rd      <= '0;
            skid_taken   <= 1'b0;
            skid_illegal <= 1'b0;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next != 2'd2);
            if (!Flush) begin
                if (accept && load_head_new) begin
                    head_result  <= Result;
                    head_rd      <= new_rd;
                    head_taken   <= new_taken;
                    head_illegal <= new_illegal;
                end else if (pop && count == 2'd2) begin
                    head_result  <= skid_result;
                    head_rd      <= skid_rd;
                    head_taken   <= skid_taken;
                    head_illegal <= skid_illegal;
                end
                if (accept && !load_head_new) begin
                    skid_result  <= Result;
                    skid_rd      <= new_rd;
                    skid_taken   <= new_taken;
                    skid_illegal <= new_illegal;
                end
            end
        end
    end

    // Data is left in place when the buffer empties; OutValid alone qualifies it.
    assign OutResult  = head_result;
    assign OutRd      = head_rd;
    assign OutTaken   = head_taken;
    assign OutIllegal = head_illegal;

endmodule

// File: tb/tb_ex_alu_issue.sv
// Directed bench for ex_alu_issue: a small alu model closes the ALU loop, outputs are
// sampled 1ns after the rising edge, and popped results are matched against exp_q.
module tb_ex_alu_issue;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_alu_op = 2'b00;
    logic [2:0]    in_funct3 = 3'b000;
    logic          in_funct7b5 = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [RW-1:0] in_rd = '0;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_ctl;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_taken;
    logic          out_illegal;

    int errors = 0;
    int checks = 0;
    logic          mon_en = 1'b0;
    logic [DW-1:0] exp_q[$];

    ex_alu_issue #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .Flush(flush),
        .InValid(in_valid), .InReady(in_ready),
        .InALUOp(in_alu_op), .InFunct3(in_funct3), .InFunct7b5(in_funct7b5),
        .InA(in_a), .InB(in_b), .InRd(in_rd),
        .A(alu_a), .B(alu_b), .ALUCtl(alu_ctl),
        .Result(alu_result), .Zero(alu_zero),
        .OutValid(out_valid), .OutReady(out_ready),
        .OutResult(out_result), .OutRd(out_rd),
        .OutTaken(out_taken), .OutIllegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference model of the external combinational alu.
    always_comb begin
        case (alu_ctl)
            4'h0:    alu_result = alu_a + alu_b;
            4'h1:    alu_result = alu_a - alu_b;
            4'h2:    alu_result = alu_a << alu_b[4:0];
            4'h3:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'h4:    alu_result = {31'd0, alu_a < alu_b};
            4'h5:    alu_result = alu_a ^ alu_b;
            4'h6:    alu_result = alu_a >> alu_b[4:0];
            4'h7:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'h8:    alu_result = alu_a | alu_b;
            4'h9:    alu_result = alu_a & alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RW-1:0] rd);
        in_alu_op   = op;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_a        = a;
        in_b        = b;
        in_rd       = rd;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RW-1:0] rd,
                          input logic [3:0] e_ctl, input logic [DW-1:0] e_res, input logic [RW-1:0] e_rd,
                          input logic e_taken, input logic e_ill);
        set_op(op, f3, f7, a, b, rd);
        in_valid = 1'b1;
        #1;
        check({tag, "_ctl"}, alu_ctl, e_ctl);
        check({tag, "_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_result"}, out_result, e_res);
        check({tag, "_rd"}, out_rd, e_rd);
        check({tag, "_taken"}, out_taken, e_taken);
        check({tag, "_illegal"}, out_illegal, e_ill);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            logic [DW-1:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_result;
            check("pop_order", out_result, e);
        end
    end

    // Decode-only vectors: {ALUOp, funct3, f7b5, expected ALUCtl}.
    logic [9:0] ctl_tab [14] = '{
        {2'b10, 3'b001, 1'b0, 4'h2}, {2'b10, 3'b010, 1'b0, 4'h3}, {2'b10, 3'b011, 1'b0, 4'h4},
        {2'b10, 3'b100, 1'b0, 4'h5}, {2'b10, 3'b101, 1'b0, 4'h6}, {2'b10, 3'b101, 1'b1, 4'h7},
        {2'b10, 3'b110, 1'b0, 4'h8}, {2'b10, 3'b111, 1'b0, 4'h9}, {2'b11, 3'b101, 1'b1, 4'h7},
        {2'b11, 3'b010, 1'b0, 4'h3}, {2'b00, 3'b111, 1'b1, 4'h0}, {2'b01, 3'b101, 1'b0, 4'h3},
        {2'b01, 3'b111, 1'b0, 4'h4}, {2'b01, 3'b011, 1'b0, 4'hF}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_rd", out_rd, 5'd0);
        check("rst_out_taken", out_taken, 1'b0);
        check("rst_out_illegal", out_illegal, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            logic [9:0] v;
            v = ctl_tab[i];
            set_op(v[9:8], v[7:5], v[4], 32'd0, 32'd0, 5'd0);
            #1;
            check($sformatf("decode_%0d", i), alu_ctl, v[3:0]);
        end

        out_ready = 1'b1;
        run_op("add",  2'b10, 3'b000, 1'b0, 32'd1,        32'd2, 5'd5, 4'h0, 32'd3, 5'd5, 1'b0, 1'b0);
        run_op("sub",  2'b10, 3'b000, 1'b1, 32'd20,       32'd20, 5'd6, 4'h1, 32'd0, 5'd6, 1'b0, 1'b0);
        run_op("addi", 2'b11, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd7, 4'h0, 32'd0, 5'd7, 1'b0, 1'b0);
        run_op("beq",  2'b01, 3'b000, 1'b0, 32'd7,        32'd7, 5'd9, 4'h1, 32'd0, 5'd0, 1'b1, 1'b0);
        run_op("bne",  2'b01, 3'b001, 1'b0, 32'd7,        32'd7, 5'd9, 4'h1, 32'd0, 5'd0, 1'b0, 1'b0);
        run_op("blt",  2'b01, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd9, 4'h3, 32'd1, 5'd0, 1'b1, 1'b0);
        run_op("bltu", 2'b01, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd9, 4'h4, 32'd0, 5'd0, 1'b0, 1'b0);
        run_op("bill", 2'b01, 3'b010, 1'b0, 32'd3,        32'd4, 5'd9, 4'hF, 32'd0, 5'd0, 1'b0, 1'b1);
        tick();
        check("drain_valid", out_valid, 1'b0);

        // Backpressure: three ops while MEM stalls.
        mon_en = 1'b1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        out_ready = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 32'd1, 32'd0, 5'd1);
        in_valid = 1'b1;
        tick();
        check("bp_ready_1", in_ready, 1'b1);
        set_op(2'b00, 3'b000, 1'b0, 32'd1, 32'd1, 5'd2);
        tick();
        check("bp_ready_2", in_ready, 1'b0);
        set_op(2'b00, 3'b000, 1'b0, 32'd2, 32'd1, 5'd3);
        tick();
        check("bp_hold_ready", in_ready, 1'b0);
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_result", out_result, 32'd1);
        tick();
        check("bp_stable_result", out_result, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_ready_after_pop", in_ready, 1'b1);
        check("bp_head_2", out_result, 32'd2);
        tick();
        in_valid = 1'b0;
        check("bp_head_3", out_result, 32'd3);
        tick();
        check("bp_empty", out_valid, 1'b0);
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Simultaneous accept and pop at count=1.
        for (int i = 0; i <= 10; i++) begin
            set_op(2'b00, 3'b000, 1'b0, i, 32'd100, 5'd1);
            in_valid = 1'b1;
            exp_q.push_back(32'd100 + i);
            tick();
            check("st_ready", in_ready, 1'b1);
            check("st_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check("st_empty", out_valid, 1'b0);
        check("st_queue_empty", exp_q.size(), 32'd0);

        // Flush at count=2 with InValid held high; nothing may pop afterwards.
        out_ready = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 32'd5, 32'd0, 5'd1);
        in_valid = 1'b1;
        tick();
        set_op(2'b00, 3'b000, 1'b0, 32'd6, 32'd0, 5'd1);
        tick();
        check("fl_full", in_ready, 1'b0);
        set_op(2'b00, 3'b000, 1'b0, 32'd7, 32'd0, 5'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 1'b0);
        check("fl_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_stays_empty", out_valid, 1'b0);
        end

        // Flush at count=1 while an op is being accepted.
        out_ready = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 32'd8, 32'd0, 5'd1);
        in_valid = 1'b1;
        tick();
        set_op(2'b00, 3'b000, 1'b0, 32'd9, 32'd0, 5'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_valid", out_valid, 1'b0);
        check("fl1_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        check("fl1_stays_empty", out_valid, 1'b0);

        // Asynchronous reset mid-cycle with the buffer full.
        mon_en = 1'b0;
        out_ready = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 32'h11, 32'd0, 5'd3);
        in_valid = 1'b1;
        tick();
        set_op(2'b00, 3'b000, 1'b0, 32'h22, 32'd0, 5'd4);
        tick();
        in_valid = 1'b0;
        check("ar_pre_result", out_result, 32'h11);
        check("ar_pre_rd", out_rd, 5'd3);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_result", out_result, 32'h0);
        check("ar_rd", out_rd, 5'd0);
        check("ar_ready", in_ready, 1'b1);
        #1;
        rst = 1'b0;
        tick();
        check("ar_after_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        run_op("post_rst", 2'b00, 3'b000, 1'b0, 32'd4, 32'd5, 5'd7, 4'h0, 32'd9, 5'd7, 1'b0, 1'b0);
        tick();
        check("post_rst_drain", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
